// File: rtl/mac_result_accumulator_if.sv
// Handshake bundle between the MAC partial-result stream, the accumulator and
// the downstream consumer of finished dot-product words.
interface mac_result_accumulator_if #(
  parameter int PROD_WIDTH = 16,
  parameter int ACC_WIDTH  = 20
);
  logic                  in_valid;
  logic                  in_ready;
  logic [PROD_WIDTH-1:0] in_sum;
  logic                  in_carry;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_data;
  logic                  out_ovf;

  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/mac_result_accumulator.sv
// Sums a programmable number of MAC partials ({carry, sum}) into one saturating
// wide word and holds it on a valid/ready port, stalling upstream until taken.
module mac_result_accumulator #(
  parameter int PROD_WIDTH = 16,
  parameter int ACC_WIDTH  = 20,
  parameter int MAX_BEATS  = 16,
  parameter int CNT_WIDTH  = $clog2(MAX_BEATS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] cfg_beats,
  mac_result_accumulator_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for the first beat of a new result
  // ACCUM | summing beats until count reaches the latched beat total
  // DONE  | result presented downstream, upstream stalled
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  localparam logic [CNT_WIDTH-1:0] max_beats_c = CNT_WIDTH'(MAX_BEATS);

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   beats_q, beats_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]   eff_beats;
  logic [CNT_WIDTH-1:0]   cnt_inc;
  logic [ACC_WIDTH:0]     partial;
  logic [ACC_WIDTH:0]     sum;
  logic                   accept;

  assign eff_beats = (cfg_beats == '0)         ? CNT_WIDTH'(1) :
                     (cfg_beats > max_beats_c) ? max_beats_c   : cfg_beats;
  assign partial   = {{(ACC_WIDTH-PROD_WIDTH){1'b0}}, bus.in_carry, bus.in_sum};
  assign sum       = {1'b0, acc_q} + partial;
  assign cnt_inc   = cnt_q + CNT_WIDTH'(1);
  assign accept    = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      beats_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    beats_d = beats_q;
    ovf_d   = ovf_q;
    if (clear) begin
      // flush wins over any beat or handshake in the same cycle
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      beats_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            beats_d = eff_beats;
            acc_d   = partial[ACC_WIDTH-1:0];
            cnt_d   = CNT_WIDTH'(1);
            state_d = (eff_beats == CNT_WIDTH'(1)) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            if (sum[ACC_WIDTH]) begin
              acc_d = '1;
              ovf_d = 1'b1;
            end else begin
              acc_d = sum[ACC_WIDTH-1:0];
            end
            cnt_d = cnt_inc;
            if (cnt_inc == beats_q) state_d = DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // out_* come straight from flops; only in_ready sees rst combinationally
  always_comb begin
    bus.in_ready  = !rst && (state_q != DONE);
    bus.out_valid = (state_q == DONE);
    bus.out_data  = acc_q;
    bus.out_ovf   = ovf_q;
  end
endmodule

// File: tb/tb_mac_result_accumulator.sv
// Scoreboard bench: the driver pushes the expected saturated total of each run,
// a monitor pops and compares it on every output handshake.
module tb_mac_result_accumulator;
  localparam int ACC_MAX = 20'hFFFFF;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [4:0] cfg_beats;

  mac_result_accumulator_if #(.PROD_WIDTH(16), .ACC_WIDTH(20)) bus ();

  mac_result_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .cfg_beats (cfg_beats),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [20:0] exp_q[$];
  logic [16:0] beats_q[$];
  logic [20:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // monitor: sample just after the driver updates inputs, well before the edge
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result actual=%h required=none", bus.out_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result_data", 32'(bus.out_data), 32'(mon_e[19:0]));
          chk("result_ovf", 32'(bus.out_ovf), 32'(mon_e[20]));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // present one beat and hold it until accepted; returns at posedge+1
  task automatic send_beat(input logic [16:0] p, output bit ok);
    int n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_carry = p[16];
    bus.in_sum   = p[15:0];
    #1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    ok = bus.in_ready;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // sends beats_q, checks completion timing, holds off out_ready for bp cycles
  task automatic run_txn(input int cfg, input int cfg2, input int gap, input int bp);
    longint      s = 0;
    bit          eo;
    logic [19:0] ed;
    bit          ok;
    int          nb = beats_q.size();
    foreach (beats_q[i]) s += longint'(beats_q[i]);
    eo = (s > longint'(ACC_MAX));
    ed = eo ? 20'hFFFFF : s[19:0];
    cfg_beats = 5'(cfg);
    for (int i = 0; i < nb; i++) begin
      if (i > 0) repeat (gap) @(negedge clk);
      send_beat(beats_q[i], ok);
      chk("beat_accept", 32'(ok), 32'd1);
      if (i == 0) cfg_beats = 5'(cfg2);
      chk("valid_timing", 32'(bus.out_valid), 32'(i == nb - 1));
    end
    exp_q.push_back({eo, ed});
    bus.in_valid = 1'b1;
    bus.in_carry = 1'($urandom);
    bus.in_sum   = 16'($urandom);
    repeat (bp) begin
      @(negedge clk);
      #1;
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_data", 32'(bus.out_data), 32'(ed));
      chk("bp_ovf", 32'(bus.out_ovf), 32'(eo));
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("post_hs_valid", 32'(bus.out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    chk("post_hs_data", 32'(bus.out_data), 32'd0);
    beats_q.delete();
  endtask

  task automatic random_runs(input int n);
    int cfg;
    int eff;
    bit hot;
    for (int t = 0; t < n; t++) begin
      cfg = int'($urandom_range(0, 31));
      eff = (cfg == 0) ? 1 : (cfg > 16) ? 16 : cfg;
      hot = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < eff; i++)
        beats_q.push_back(hot ? {1'b1, 16'($urandom)} : 17'($urandom_range(0, 32'h1FFFF)));
      run_txn(cfg, int'($urandom_range(0, 31)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    bit ok;
    rst           = 1'b1;
    clear         = 1'b0;
    cfg_beats     = 5'd4;
    bus.in_valid  = 1'b0;
    bus.in_carry  = 1'b0;
    bus.in_sum    = '0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    beats_q = '{17'h00100, 17'h00200, 17'h00300, 17'h10000};
    run_txn(4, 4, 0, 0);

    beats_q = '{17'h00001, 17'h00002, 17'h00003};
    run_txn(3, 3, 2, 5);

    for (int i = 0; i < 16; i++) beats_q.push_back(17'h1FFFF);
    run_txn(16, 16, 0, 1);
    beats_q = '{17'h00007};
    run_txn(1, 1, 0, 0);

    beats_q = '{17'h00042};
    run_txn(0, 0, 0, 0);
    for (int i = 0; i < 16; i++) beats_q.push_back(17'(i + 1));
    run_txn(31, 31, 0, 0);
    beats_q = '{17'h00011, 17'h00022, 17'h00033, 17'h00044};
    run_txn(4, 2, 1, 0);

    // reset in the middle of a run
    cfg_beats = 5'd4;
    send_beat(17'h00010, ok);
    send_beat(17'h00010, ok);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    beats_q = '{17'h00005};
    run_txn(1, 1, 0, 0);

    // clear discards a pending result
    cfg_beats = 5'd3;
    for (int i = 0; i < 3; i++) send_beat(17'h00100, ok);
    chk("clr_done_valid", 32'(bus.out_valid), 32'd1);
    chk("clr_done_data", 32'(bus.out_data), 32'h300);
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_valid", 32'(bus.out_valid), 32'd0);
    chk("clr_in_ready", 32'(bus.in_ready), 32'd1);
    chk("clr_data", 32'(bus.out_data), 32'd0);

    // beat coincident with clear is dropped
    cfg_beats = 5'd2;
    send_beat(17'h00011, ok);
    @(negedge clk);
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_carry = 1'b0;
    bus.in_sum   = 16'h0500;
    @(posedge clk);
    #1;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_beat_valid", 32'(bus.out_valid), 32'd0);
    beats_q = '{17'h00001, 17'h00002};
    run_txn(2, 2, 0, 0);

    random_runs(30);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
